// File: rtl/mux_n_reg.sv
// N-channel WIDTH-bit selector with a one-entry registered output stage.
// Channel choice is either fixed (by i_sel) or round-robin among valid channels.
module mux_n_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N*WIDTH-1:0]   i_ip,
  input  logic [N-1:0]         i_ip_valid,
  output logic [N-1:0]         o_ip_ready,
  input  logic                 i_mode,
  input  logic [SELW-1:0]      i_sel,
  output logic [WIDTH-1:0]     o_op,
  output logic [SELW-1:0]      o_op_ch,
  output logic                 o_op_valid,
  input  logic                 i_op_ready
);

  logic [WIDTH-1:0] r_op;
  logic [SELW-1:0]  r_op_ch;
  logic             r_op_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_grant_idx;
  logic [WIDTH-1:0] w_grant_data;
  logic             w_found;
  logic             w_can_accept;
  logic             w_in_hs;
  int               w_j;

  // Grant: fixed select, or first valid channel after r_rr_ptr (wrapping modulo N)
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_j         = 0;
    if (i_mode == 1'b0) begin
      for (int i = 0; i < N; i++) begin
        if (i_sel == SELW'(i)) begin
          w_grant[i] = i_ip_valid[i];
        end else begin
          w_grant[i] = 1'b0;
        end
      end
      w_grant_idx = i_sel;
    end else begin
      for (int k = 0; k < N; k++) begin
        w_j = int'(r_rr_ptr) + 1 + k;
        if (w_j >= N) begin
          w_j = w_j - N;
        end else begin
          w_j = w_j;
        end
        for (int i = 0; i < N; i++) begin
          if (!w_found && (w_j == i) && i_ip_valid[i]) begin
            w_found     = 1'b1;
            w_grant[i]  = 1'b1;
            w_grant_idx = SELW'(i);
          end else begin
            w_found = w_found;
          end
        end
      end
    end
  end

  // Data of the granted channel (zero when nothing is granted)
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_grant_data = i_ip[i*WIDTH +: WIDTH];
      end else begin
        w_grant_data = w_grant_data;
      end
    end
  end

  // Reset blocks acceptance so nothing is taken in a cycle whose load is discarded
  assign w_can_accept = !r_op_valid || i_op_ready;
  assign o_ip_ready   = w_grant & {N{w_can_accept && !i_rst}};
  assign w_in_hs      = |(i_ip_valid & o_ip_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op       <= '0;
      r_op_ch    <= '0;
      r_op_valid <= 1'b0;
      r_rr_ptr   <= SELW'(N - 1);
    end else if (w_in_hs) begin
      r_op       <= w_grant_data;
      r_op_ch    <= w_grant_idx;
      r_op_valid <= 1'b1;
      if (i_mode) begin
        r_rr_ptr <= w_grant_idx;
      end
    end else if (r_op_valid && i_op_ready) begin
      r_op_valid <= 1'b0;
    end
  end

  assign o_op       = r_op;
  assign o_op_ch    = r_op_ch;
  assign o_op_valid = r_op_valid;

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-channel, WIDTH-bit selector with a registered output stage and valid/ready handshakes on every channel and on the output.
- Two selection modes: fixed (channel chosen by `sel`) and round-robin (fair arbitration among valid channels).
- Sits between datapath producers (register file, ALU, immediate path) and a single consumer stage in the 8-bit RISC pipeline.
- Replaces the plain combinational 2:1 operand mux wherever back-pressure or more sources are needed.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- N, 4, number of input channels; legal range 2..16.
- SELW, 2, width of `sel` and `op_ch`; must satisfy 2^SELW >= N.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- ip  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- ip_valid  input  N  per-channel data valid.
- ip_ready  output  N  per-channel accept; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- op  output  WIDTH  registered output data.
- op_ch  output  SELW  index of the channel that supplied `op`.
- op_valid  output  1  output data valid.
- op_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at a clk edge):
  - op=0, op_ch=0, op_valid=0.
  - rr_ptr=N-1, so channel 0 has first priority after reset.
  - Reset wins over any simultaneous handshake; in-flight data is discarded.
- can_accept = !op_valid || op_ready (one-entry output register with pass-through refill).
- Grant is combinational and one-hot or zero:
  - Fixed mode: grant[sel]=1 iff sel<N and ip_valid[sel]=1.
  - sel>=N gives no grant; all ip_ready=0.
  - Round-robin mode: the first valid channel scanning rr_ptr+1, rr_ptr+2, ... modulo N.
  - No valid channel gives no grant.
- ip_ready[i] = grant[i] && can_accept.
  - ip_ready must not depend on ip_valid of channel i in fixed mode except via grant.
  - Handshake on channel i when ip_valid[i] && ip_ready[i].
- On an input handshake at a clk edge: op <= channel data, op_ch <= granted index, op_valid <= 1.
  - Latency: 1 cycle from input handshake to op_valid.
- On an output handshake (op_valid && op_ready) with no new input handshake: op_valid <= 0.
  - op and op_ch hold their last values.
- Simultaneous output and input handshakes in the same cycle: the register reloads, op_valid stays 1.
  - Full throughput is one transfer per cycle.
- When op_valid=1 and op_ready=0: op and op_ch must stay stable; no input is accepted.
- rr_ptr <= granted index only on an input handshake while mode=1.
  - Fixed-mode transfers leave rr_ptr unchanged.
- mode and sel are sampled every cycle.
  - A change affects the grant in the same cycle.
  - A change never corrupts a held output.
- Wrap-around: after a grant on channel N-1, channel 0 has top priority.
- N=2, mode=0, op_ready tied 1 gives the classic 2:1 selector with one register stage.

Test Plan:
- Reset: assert rst for 2 cycles with all ip_valid=1, op_ready=1 -> op=0, op_valid=0, op_ch=0 during and one cycle after; ip_ready=0 while rst=1.
- Fixed mode: WIDTH=8, N=4, mode=0, sel=2, ip ch2=8'hA5, all valid, op_ready=1 -> ip_ready=4'b0100; next cycle op=8'hA5, op_ch=2, op_valid=1. Then sel=3'd… with N=3 build, sel=3 -> ip_ready=0, op_valid drops after the drain.
- Back-pressure: op_valid=1, op_ready=0 for 3 cycles while ch1 changes 8'h11->8'h22 -> op and op_ch frozen, ip_ready all 0; op_ready=1 -> same-cycle reload, op_valid stays 1 with the new data the next cycle.
- Round-robin fairness: mode=1, all 4 channels valid continuously, op_ready=1 -> op_ch sequence 0,1,2,3,0,1 with no bubbles.
- Round-robin skip/wrap: mode=1, only ch3 and ch0 valid, rr_ptr=3 -> ch0 granted first, then ch3, then ch0.
- Mid-operation reset: rst asserted the same cycle as input and output handshakes -> op_valid=0, rr_ptr=N-1 next cycle; first post-reset round-robin grant goes to the lowest valid channel.
